// File: rtl/pcm_frame_scheduler.sv
// Purpose : snapshots one PCM frame of NCH channel samples on pcm_stb and
//           serialises the enabled channels, lowest index first, onto a
//           valid/ready word stream.
// Latency : pcm_stb in cycle t gives the first word in cycle t+1. Words are
//           back-to-back with no bubbles, and a new frame may start on the
//           last-word handshake.
// Backpr. : out_ready=0 holds the current word. A pcm_stb that arrives
//           mid-frame (other than on the last-word handshake) drops the new
//           frame and pulses overrun.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   pcm_stb             one-cycle frame strobe
//   ch_val [NCH*WIDTH]  channel samples; channel i is at [i*WIDTH +: WIDTH]
//   ch_en  [NCH]        per-channel enable, sampled with pcm_stb
//   out_ready           sink accepts the current word
//   out_valid/out_data/out_ch/out_last
//                       word stream; the data fields are 0 when not valid
//   busy                a frame is being sent
//   overrun             one-cycle pulse when a frame is dropped
//   ovr_cnt [8]         saturating overrun count; only present when
//                       PCM_FRAME_SCHEDULER_OVR_CNT_EN is defined

module pcm_frame_scheduler #(
  parameter int NCH   = 3,
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pcm_stb,
  input  logic [NCH*WIDTH-1:0] ch_val,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [2:0]           out_ch,
  output logic                 out_last,
  output logic                 busy,
  output logic                 overrun
`ifdef PCM_FRAME_SCHEDULER_OVR_CNT_EN
  ,
  output logic [7:0]           ovr_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NCH-1:0]       mask_q, mask_d;
  logic [NCH*WIDTH-1:0] snap_q, snap_d;

  logic [NCH-1:0]       cur_onehot;
  logic [2:0]           cur_idx;
  logic [WIDTH-1:0]     cur_data;
  logic                 cur_last;
  logic                 send_hs;
  logic                 last_hs;
  logic                 ovr_pulse;

  // Isolate the lowest pending bit with the two's-complement trick. The
  // current word is last when no other pending bit remains.
  assign cur_onehot = mask_q & (~mask_q + NCH'(1));
  assign cur_last   = ((mask_q & ~cur_onehot) == '0);

  always_comb begin
    cur_idx  = '0;
    cur_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cur_onehot[i]) begin
        cur_idx  = 3'(i);
        cur_data = snap_q[i*WIDTH +: WIDTH];
      end
    end
  end

  assign send_hs = (state_q == SEND) && out_ready;
  assign last_hs = send_hs && cur_last;

  // Next-state logic. A strobe is accepted in IDLE, or in SEND only on the
  // cycle where the final word is handed off; otherwise the frame is dropped.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    snap_d    = snap_q;
    ovr_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (pcm_stb) begin
          snap_d  = ch_val;
          mask_d  = ch_en;
          state_d = (|ch_en) ? SEND : IDLE;
        end
      end
      SEND: begin
        if (send_hs) begin
          mask_d = mask_q & ~cur_onehot;
        end
        if (last_hs) begin
          state_d = IDLE;
          if (pcm_stb) begin
            snap_d  = ch_val;
            mask_d  = ch_en;
            state_d = (|ch_en) ? SEND : IDLE;
          end
        end else if (pcm_stb) begin
          ovr_pulse = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      snap_q  <= snap_d;
    end
  end

  // All outputs decode from state, so asserting reset zeroes them at once.
  always_comb begin
    out_valid = (state_q == SEND);
    busy      = (state_q == SEND);
    overrun   = ovr_pulse;
    out_data  = '0;
    out_ch    = '0;
    out_last  = 1'b0;
    if (state_q == SEND) begin
      out_data = cur_data;
      out_ch   = cur_idx;
      out_last = cur_last;
    end
  end

`ifdef PCM_FRAME_SCHEDULER_OVR_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (ovr_pulse && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign ovr_cnt = ovr_cnt_q;
`endif

endmodule
